cond_exec_unit: RTL
===================

// Module: cond_exec_unit
// PURPOSE
//  Parametrised conditional-execution unit for the pipelined ARM core's execute stage. Holds the
//  flag register with per-group write enables and evaluates the instruction condition. Gates
//  PCSrc/RegWrite/MemWrite. Adds an IT-block predication FSM (up to IT_DEPTH instructions) and an
//  exception shadow copy of flags plus IT state. Sits between decoder/ALU and the writeback/PC muxes.
// PARAMETERS
//  NFLAGS      4  flag bits, MSB-first N,Z,C,V; NFLAGS % FLAG_GROUPS == 0
//  FLAG_GROUPS 2  write-enable groups; group g = Flags[(g+1)*GW-1 : g*GW], GW = NFLAGS/FLAG_GROUPS
//  IT_DEPTH    4  max instructions predicated by one IT block (>=1)
// PORTS
//  clk          in  1            core clock, rising edge
//  rst          in  1            asynchronous, active-high reset
//  valid        in  1            execute-stage instruction present
//  stall        in  1            execute stage held; accept = valid & ~stall
//  flush        in  1            pipeline flush; clears IT state
//  Cond         in  4            instruction condition field
//  ALUFlags     in  NFLAGS       flags from ALU this cycle
//  FlagW        in  FLAG_GROUPS  per-group flag write request
//  PCS,RegW,MemW in 1 each       unconditional strobes from decoder
//  it_start     in  1            current instruction is IT
//  it_cond      in  4            IT base condition
//  it_len       in  $clog2(IT_DEPTH+1)  predicated instruction count, 1..IT_DEPTH
//  it_te        in  IT_DEPTH     bit i: 1 = slot i uses it_cond, 0 = uses it_cond ^ 4'b0001
//  exc_save     in  1            copy Flags + IT state into shadow
//  exc_restore  in  1            reload Flags + IT state from shadow
//  PCSrc,RegWrite,MemWrite out 1 gated strobes
//  CondEx       out 1            effective condition passed (0 when not accept)
//  Flags        out NFLAGS       architectural flag register
//  it_active    out 1            IT block in progress
//  it_remaining out $clog2(IT_DEPTH+1) slots left
// BEHAVIOUR
//  - Reset: Flags=0, FSM=IDLE, it_remaining=0, slot index=0, shadow=0; outputs 0.
//  - Effective cond: IDLE -> Cond; ACTIVE -> slot cond from stored it_cond/it_te[idx].
//    Instruction Cond is ignored in ACTIVE.
//  - CondEx is combinational on current Flags (ARM table EQ..AL); 4'b1111 (NV) -> 0.
//    Forced 0 when ~accept.
//  - Strobe outputs = strobe & CondEx, combinational, zero latency.
//  - Flag group g updates at the next edge iff accept & CondEx & FlagW[g] & ~exc_restore.
//    Other groups hold.
//  - FSM IDLE: accept & it_start & it_len!=0 -> ACTIVE. Load cond, te, remaining=it_len, idx=0.
//    The IT instruction itself gets CondEx=1 and all strobes/FlagW are ignored.
//  - FSM IDLE: it_len==0 or it_len>IT_DEPTH -> IT treated as NOP; stay IDLE.
//  - FSM ACTIVE: each accept -> remaining-1, idx+1, independent of CondEx. remaining 1->0 -> IDLE.
//  - ACTIVE, it_start accepted: it_start is ignored. The instruction consumes a slot as normal.
//  - ACTIVE, accepted PCSrc=1 (taken branch): -> IDLE next edge, remaining=0.
//  - flush: -> IDLE, remaining=0; Flags unchanged. Flush beats accept and it_start in the same cycle.
//  - exc_save: shadow <= {Flags, FSM, remaining, idx, cond, te}, using values before this edge's update.
//  - exc_restore: live state <= shadow. Beats accept, flush and exc_save in the same cycle.
//  - Stall/valid=0: no state change except flush/save/restore.
//  - Asynchronous rst mid-IT-block: immediate return to reset values; shadow also cleared.
// STRUCTURE
//  - Package cond_pkg: cond_e enum (EQ=0..AL=14, NV=15), flag index localparams (N,Z,C,V),
//    it_state_e {IT_IDLE, IT_ACTIVE}, shadow struct typedef.
//  - Sub-module cond_eval: combinational (cond, flags) -> pass, NV -> 0.
//    Instantiated once on the effective cond.
//  - Flag groups: generate loop of enabled flops with asynchronous reset.
//    FSM and shadow live in this module.
// TESTING
//  1. Reset: assert rst mid-run -> Flags=0, it_active=0, all strobes 0 within the same cycle.
//  2. Group write: Flags=0, ALUFlags=4'b1111, FlagW=2'b10, Cond=AL -> Flags=4'b1100.
//     Then Cond=EQ, RegW=1 -> RegWrite=1.
//  3. Cond fail: Flags Z=0, Cond=EQ, MemW=1, FlagW=2'b11 -> MemWrite=0, Flags unchanged.
//     Cond=NV -> CondEx=0.
//  4. IT: Z=1, it_start, it_cond=EQ, it_len=3, it_te=4'b0101, 3 accepts with RegW=1 ->
//     RegWrite 1,0,1. A stall cycle between accepts changes nothing. it_active drops after the 3rd.
//  5. IT break: it_len=4, taken branch at slot 1 -> it_active=0 next cycle.
//     Same-cycle flush + it_start -> stays IDLE.
//  6. Exception: in IT, remaining=2, Flags=4'b0110; exc_save, two further accepts with flag writes,
//     then exc_restore -> Flags=4'b0110, remaining=2. Restore + FlagW in the same cycle -> write dropped.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared types for the conditional-execution unit: ARM condition codes,
// flag bit positions within the NZCV nibble, and IT-block control state.
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'd0, NE, CS, CC, MI, PL, VS, VC,
        HI, LS, GE, LT, GT, LE, AL, NV
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        IT_IDLE   = 1'b0,
        IT_ACTIVE = 1'b1
    } it_state_e;

    // Width-independent part of the exception shadow; sized fields live in the top.
    typedef struct packed {
        it_state_e state;
        cond_e     cond;
    } shadow_ctrl_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition check: returns 1 when cond holds for the given NZCV.
module cond_eval
    import cond_pkg::*;
(
    input  cond_e       cond,
    input  logic [3:0]  nzcv,
    output logic        pass
);

    logic n, z, c, v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    always_comb begin
        case (cond)
            EQ: pass = z;
            NE: pass = ~z;
            CS: pass = c;
            CC: pass = ~c;
            MI: pass = n;
            PL: pass = ~n;
            VS: pass = v;
            VC: pass = ~v;
            HI: pass = c & ~z;
            LS: pass = ~c | z;
            GE: pass = (n == v);
            LT: pass = (n != v);
            GT: pass = ~z & (n == v);
            LE: pass = z | (n != v);
            AL: pass = 1'b1;
            NV: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_exec_unit.sv
// Execute-stage conditional execution: flag register with grouped write enables,
// condition gating of PC/register/memory strobes, IT-block predication and exception shadow.
module cond_exec_unit
    import cond_pkg::*;
#(
    parameter int NFLAGS      = 4,
    parameter int FLAG_GROUPS = 2,
    parameter int IT_DEPTH    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           valid,
    input  logic                           stall,
    input  logic                           flush,
    input  logic [3:0]                     Cond,
    input  logic [NFLAGS-1:0]              ALUFlags,
    input  logic [FLAG_GROUPS-1:0]         FlagW,
    input  logic                           PCS,
    input  logic                           RegW,
    input  logic                           MemW,
    input  logic                           it_start,
    input  logic [3:0]                     it_cond,
    input  logic [$clog2(IT_DEPTH+1)-1:0]  it_len,
    input  logic [IT_DEPTH-1:0]            it_te,
    input  logic                           exc_save,
    input  logic                           exc_restore,
    output logic                           PCSrc,
    output logic                           RegWrite,
    output logic                           MemWrite,
    output logic                           CondEx,
    output logic [NFLAGS-1:0]              Flags,
    output logic                           it_active,
    output logic [$clog2(IT_DEPTH+1)-1:0]  it_remaining
);

    localparam int GW = NFLAGS / FLAG_GROUPS;
    localparam int RW = $clog2(IT_DEPTH + 1);
    localparam int IW = (IT_DEPTH > 1) ? $clog2(IT_DEPTH) : 1;

    typedef struct packed {
        logic [NFLAGS-1:0]   flags;
        shadow_ctrl_t        ctrl;
        logic [RW-1:0]       rem;
        logic [IW-1:0]       idx;
        logic [IT_DEPTH-1:0] te;
    } shadow_t;

    it_state_e           state_q, state_d;
    cond_e               itc_q, itc_d;
    logic [RW-1:0]       rem_q, rem_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [IT_DEPTH-1:0] te_q, te_d;
    shadow_t             shadow_q, shadow_d;
    logic [NFLAGS-1:0]   flags_q;

    logic  accept, it_instr, cond_pass, exec, flag_we;
    cond_e slot_cond, eff_cond;

    // Reset also masks accept so every strobe reads 0 while rst is high.
    assign accept    = valid & ~stall & ~rst;
    assign it_instr  = (state_q == IT_IDLE) & it_start;
    assign slot_cond = te_q[idx_q] ? itc_q : cond_e'(itc_q ^ 4'b0001);
    assign eff_cond  = (state_q == IT_ACTIVE) ? slot_cond : cond_e'(Cond);

    cond_eval u_cond_eval (
        .cond (eff_cond),
        .nzcv (flags_q[NFLAGS-1 -: 4]),
        .pass (cond_pass)
    );

    // The IT instruction itself always passes but never writes anything.
    assign CondEx   = accept & (it_instr | cond_pass);
    assign exec     = CondEx & ~it_instr;
    assign PCSrc    = PCS  & exec;
    assign RegWrite = RegW & exec;
    assign MemWrite = MemW & exec;
    assign flag_we  = exec & ~exc_restore & ~flush;

    for (genvar g = 0; g < FLAG_GROUPS; g++) begin : g_flag_grp
        logic [GW-1:0] grp_d, grp_q;

        always_comb begin
            grp_d = grp_q;
            if (exc_restore)
                grp_d = shadow_q.flags[g*GW +: GW];
            else if (flag_we & FlagW[g])
                grp_d = ALUFlags[g*GW +: GW];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) grp_q <= '0;
            else     grp_q <= grp_d;
        end

        assign flags_q[g*GW +: GW] = grp_q;
    end

    always_comb begin
        // NOTE: every _d starts from its _q so paths that do not assign it hold state, not infer a latch.
        state_d  = state_q;
        itc_d    = itc_q;
        rem_d    = rem_q;
        idx_d    = idx_q;
        te_d     = te_q;
        shadow_d = shadow_q;

        if (exc_save && !exc_restore) begin
            shadow_d.flags      = flags_q;
            shadow_d.ctrl.state = state_q;
            shadow_d.ctrl.cond  = itc_q;
            shadow_d.rem        = rem_q;
            shadow_d.idx        = idx_q;
            shadow_d.te         = te_q;
        end

        if (exc_restore) begin
            state_d = shadow_q.ctrl.state;
            itc_d   = shadow_q.ctrl.cond;
            rem_d   = shadow_q.rem;
            idx_d   = shadow_q.idx;
            te_d    = shadow_q.te;
        end else if (flush) begin
            state_d = IT_IDLE;
            rem_d   = '0;
            idx_d   = '0;
        end else if (accept) begin
            if (state_q == IT_IDLE) begin
                // Out-of-range lengths make the IT a no-op.
                if (it_start && it_len != '0 && it_len <= RW'(IT_DEPTH)) begin
                    state_d = IT_ACTIVE;
                    itc_d   = cond_e'(it_cond);
                    te_d    = it_te;
                    rem_d   = it_len;
                    idx_d   = '0;
                end
            end else if (PCSrc || rem_q == RW'(1)) begin
                state_d = IT_IDLE;
                rem_d   = '0;
                idx_d   = '0;
            end else begin
                rem_d = rem_q - RW'(1);
                idx_d = idx_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IT_IDLE;
            itc_q    <= EQ;
            rem_q    <= '0;
            idx_q    <= '0;
            te_q     <= '0;
            shadow_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values, as the shadow copy relies on.
            state_q  <= state_d;
            itc_q    <= itc_d;
            rem_q    <= rem_d;
            idx_q    <= idx_d;
            te_q     <= te_d;
            shadow_q <= shadow_d;
        end
    end

    assign Flags        = flags_q;
    assign it_active    = (state_q == IT_ACTIVE);
    assign it_remaining = rem_q;

endmodule
